// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
package tt_sweep_pkg;

  localparam int unsigned N_IN = 4;
  localparam int unsigned TT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    FINISH
  } tt_state_e;

  function automatic logic [4:0] popcount(input logic [TT_W-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < TT_W; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable 8-bit down-counter; expired while the count sits at zero.
module tt_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       expired
);

  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != 8'd0)) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign expired = (count_q == 8'd0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 16 input vectors through a 4-input circuit, builds its truth table
// and compares it against a reference captured at start.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] expected_tt,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt_result,
  output logic            match,
  output logic [4:0]      err_count
);

  // Timer is loaded with S-1 so APPLY lasts exactly S cycles.
  localparam logic [7:0] SettleLoad = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
  localparam bit SkipApply = (SETTLE_CYCLES == 0);

  tt_state_e       state_q;
  logic [N_IN-1:0] idx_q;
  logic [N_IN-1:0] dut_in_q;
  logic [TT_W-1:0] work_q;
  logic [TT_W-1:0] exp_q;
  logic [TT_W-1:0] tt_result_q;
  logic            busy_q;
  logic            done_q;
  logic            match_q;
  logic [4:0]      err_count_q;

  logic            timer_load;
  logic            timer_expired;
  logic [TT_W-1:0] sampled_tt;
  logic            last_vec;

  // Vector 0 is shifted in first so it ends up in the MSB.
  assign sampled_tt = {work_q[TT_W-2:0], dut_out};
  assign last_vec   = (idx_q == '1);

  assign timer_load = ((state_q == IDLE) && start) || ((state_q == SAMPLE) && !last_vec);

  tt_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SettleLoad),
    .en       (state_q == APPLY),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      dut_in_q    <= '0;
      work_q      <= '0;
      exp_q       <= '0;
      tt_result_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != IDLE) && abort) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        dut_in_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              exp_q    <= expected_tt;
              idx_q    <= '0;
              dut_in_q <= '0;
              work_q   <= '0;
              busy_q   <= 1'b1;
              state_q  <= SkipApply ? SAMPLE : APPLY;
            end
          end
          APPLY: begin
            if (timer_expired) state_q <= SAMPLE;
          end
          SAMPLE: begin
            work_q <= sampled_tt;
            if (last_vec) begin
              // Results and done land in the FINISH cycle itself.
              state_q     <= FINISH;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              tt_result_q <= sampled_tt;
              match_q     <= (sampled_tt == exp_q);
              err_count_q <= popcount(sampled_tt ^ exp_q);
            end else begin
              idx_q    <= idx_q + 1'b1;
              dut_in_q <= idx_q + 1'b1;
              state_q  <= SkipApply ? SAMPLE : APPLY;
            end
          end
          FINISH: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tt_result = tt_result_q;
  assign match     = match_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: S=2 and S=0 instances with a result scoreboard.
module tb_tt_sweep_ctrl;

  typedef struct {
    logic [15:0] tt;
    logic        m;
    logic [4:0]  err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] expected_tt;
  logic        sel;

  logic        start0, abort0, dut_out0, busy0, done0, match0;
  logic        start2, abort2, dut_out2, busy2, done2, match2;
  logic [3:0]  dut_in0, dut_in2;
  logic [15:0] tt0, tt2;
  logic [4:0]  err0, err2;

  logic        obs_busy, obs_done, obs_match;
  logic [3:0]  obs_dut_in;
  logic [15:0] obs_tt;
  logic [4:0]  obs_err;

  logic [15:0] ckt_tt = 16'h2A56;
  logic [15:0] last_tt [2];
  logic        last_m [2];
  logic [4:0]  last_err [2];

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural circuits: 0x2A56 for S=2, buffer of input _0 for S=0.
  assign dut_out2 = ckt_tt[4'd15 - dut_in2];
  assign dut_out0 = dut_in0[3];

  assign start0 = sel & start;
  assign abort0 = sel & abort;
  assign start2 = ~sel & start;
  assign abort2 = ~sel & abort;

  assign obs_busy   = sel ? busy0 : busy2;
  assign obs_done   = sel ? done0 : done2;
  assign obs_match  = sel ? match0 : match2;
  assign obs_dut_in = sel ? dut_in0 : dut_in2;
  assign obs_tt     = sel ? tt0 : tt2;
  assign obs_err    = sel ? err0 : err2;

  tt_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .start       (start2),
    .abort       (abort2),
    .expected_tt (expected_tt),
    .dut_in      (dut_in2),
    .dut_out     (dut_out2),
    .busy        (busy2),
    .done        (done2),
    .tt_result   (tt2),
    .match       (match2),
    .err_count   (err2)
  );

  tt_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .start       (start0),
    .abort       (abort0),
    .expected_tt (expected_tt),
    .dut_in      (dut_in0),
    .dut_out     (dut_out0),
    .busy        (busy0),
    .done        (done0),
    .tt_result   (tt0),
    .match       (match0),
    .err_count   (err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_tt(input bit use0);
    logic [15:0] t;
    logic [3:0]  v;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      t[15-i] = use0 ? v[3] : ckt_tt[15-i];
    end
    return t;
  endfunction

  // Cycle n is observed on the negedge before edge n; inputs set there are
  // sampled at edge n. Edge 0 accepts the start.
  task automatic run(input bit use0, input logic [15:0] exp_tt, input bit expect_done,
                     input int abort_at, input int rst_at, input int re_a, input int re_b);
    int          n_done = 0;
    int          s;
    exp_t        e;
    logic [15:0] t;
    s   = use0 ? 0 : 2;
    sel = use0;
    @(negedge clk);
    expected_tt = exp_tt;
    start       = 1'b1;
    if (expect_done) begin
      t     = model_tt(use0);
      e.tt  = t;
      e.m   = (t == exp_tt);
      e.err = 5'($countones(t ^ exp_tt));
      e.cyc = 16 * (s + 1) + 1;
      sb.push_back(e);
    end
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) chk("busy_cycle1", 32'(obs_busy), 32'd1);
      if (obs_done) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("unexpected_done_cycle", n, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", n, e.cyc);
          chk("busy_at_done", 32'(obs_busy), 32'd0);
          chk("tt_result", 32'(obs_tt), 32'(e.tt));
          chk("match", 32'(obs_match), 32'(e.m));
          chk("err_count", 32'(obs_err), 32'(e.err));
          last_tt[use0]  = e.tt;
          last_m[use0]   = e.m;
          last_err[use0] = e.err;
        end
      end
      if (n == abort_at + 1) begin
        chk("abort_busy", 32'(obs_busy), 32'd0);
        chk("abort_dut_in", 32'(obs_dut_in), 32'd0);
        chk("abort_tt_hold", 32'(obs_tt), 32'(last_tt[use0]));
        chk("abort_match_hold", 32'(obs_match), 32'(last_m[use0]));
        chk("abort_err_hold", 32'(obs_err), 32'(last_err[use0]));
      end
      if (n == rst_at + 1) begin
        chk("rst_dut_in", 32'(obs_dut_in), 32'd0);
        chk("rst_busy", 32'(obs_busy), 32'd0);
        chk("rst_done", 32'(obs_done), 32'd0);
        chk("rst_tt", 32'(obs_tt), 32'd0);
        chk("rst_match", 32'(obs_match), 32'd0);
        chk("rst_err", 32'(obs_err), 32'd0);
        last_tt[0] = '0; last_m[0] = 1'b0; last_err[0] = '0;
        last_tt[1] = '0; last_m[1] = 1'b0; last_err[1] = '0;
      end
      start = (n == re_a) || (n == re_b);
      abort = (n == abort_at);
      rst   = (n == rst_at);
    end
    chk("done_count", n_done, expect_done ? 1 : 0);
    chk("scoreboard_drained", sb.size(), 0);
    chk("result_hold", 32'(obs_tt), 32'(last_tt[use0]));
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    expected_tt = '0;
    sel         = 1'b0;
    for (int i = 0; i < 2; i++) begin
      last_tt[i]  = '0;
      last_m[i]   = 1'b0;
      last_err[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_dut_in2", 32'(dut_in2), 32'd0);
    chk("reset_busy2", 32'(busy2), 32'd0);
    chk("reset_done2", 32'(done2), 32'd0);
    chk("reset_tt2", 32'(tt2), 32'd0);
    chk("reset_match2", 32'(match2), 32'd0);
    chk("reset_err2", 32'(err2), 32'd0);
    chk("reset_dut_in0", 32'(dut_in0), 32'd0);
    chk("reset_busy0", 32'(busy0), 32'd0);
    chk("reset_tt0", 32'(tt0), 32'd0);
    chk("reset_err0", 32'(err0), 32'd0);

    // Matching reference, then a one-bit-off reference.
    run(1'b0, 16'h2A56, 1'b1, -1, -1, -1, -1);
    run(1'b0, 16'h2A57, 1'b1, -1, -1, -1, -1);
    // Zero settle time, output follows input _0.
    run(1'b1, 16'h00FF, 1'b1, -1, -1, -1, -1);
    // Abort mid-sweep keeps the previous results.
    run(1'b0, 16'h1234, 1'b0, 10, -1, -1, -1);
    // Extra starts during a sweep are ignored.
    run(1'b0, 16'h2A56, 1'b1, -1, -1, 5, 20);
    // Reset mid-sweep, then a clean sweep against an all-ones reference.
    run(1'b0, 16'h2A56, 1'b0, -1, 30, -1, -1);
    run(1'b0, 16'hFFFF, 1'b1, -1, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
